// File: rtl/uart_cmd_pkg.sv
// Shared constants, state and error encodings for the UART command parser.
// Frame: AA CMD P0 P1 P2 [CHK]. CHK is present only with UART_CMD_CHECKSUM_EN.
package uart_cmd_pkg;

  localparam logic [7:0] HDR        = 8'hAA;
  localparam logic [7:0] CMD_FREQ   = 8'h01;
  localparam logic [7:0] CMD_METHOD = 8'h02;
  localparam logic [7:0] CMD_SWITCH = 8'h03;
  localparam logic [7:0] CMD_START  = 8'h04;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_CMD = 2'd1,
    ERR_BAD_CHK = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_P0,
    S_P1,
    S_P2,
    S_CHK,
    S_EXEC
  } state_e;

  function automatic logic bcd_ok(input logic [19:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART RX core into the command parser.
// master = RX core side, slave = parser side.
interface uart_cmd_parser_if;

  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/uart_byte_timer.sv
// Loadable down-counter for the inter-byte timeout.
// expire is high while enabled and the count has run out.
module uart_byte_timer #(
  parameter int unsigned LOAD = 99999
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LOAD > 0) ? $clog2(LOAD + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= W'(LOAD);
    else if (clr)
      cnt <= W'(LOAD);
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses binary command frames from the UART RX byte stream into sender controls.
// Optional checksum byte enabled by UART_CMD_CHECKSUM_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [19:0] FREQ_RST    = 20'h00010,
  parameter logic [7:0]  METHOD_RST  = 8'h40
) (
  input  logic               clk,
  input  logic               rstn,
  uart_cmd_parser_if.slave   rx,
  output logic [7:0]         method,
  output logic [19:0]        freq,
  output logic               switch,
  output logic               start_send,
  output logic               cmd_ok,
  output logic               cmd_err,
  output logic [1:0]         err_code
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, p0_q, p1_q, p2_q;
  logic        busy, tmo, byte_in;
  logic        chk_bad;
  logic [19:0] freq_new;
  logic        ok_d, err_d, set_f, set_m, set_s, go;
  err_e        code_d;

  assign busy    = !(state_q == S_IDLE || state_q == S_EXEC);
  assign byte_in = rx.rx_valid && !tmo;

  uart_byte_timer #(
    .LOAD (TIMEOUT_CYC - 1)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (rx.rx_valid),
    .en     (busy),
    .expire (tmo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (byte_in && rx.rx_data == HDR) state_d = S_CMD;
      S_CMD:  if (byte_in) state_d = S_P0;
      S_P0:   if (byte_in) state_d = S_P1;
      S_P1:   if (byte_in) state_d = S_P2;
`ifdef UART_CMD_CHECKSUM_EN
      S_P2:   if (byte_in) state_d = S_CHK;
`else
      S_P2:   if (byte_in) state_d = S_EXEC;
`endif
      S_CHK:  if (byte_in) state_d = S_EXEC;
      // a header landing in EXEC starts the next frame
      S_EXEC: state_d = (rx.rx_valid && rx.rx_data == HDR) ? S_CMD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_q <= '0;
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
    end else if (byte_in) begin
      case (state_q)
        S_CMD:   cmd_q <= rx.rx_data;
        S_P0:    p0_q  <= rx.rx_data;
        S_P1:    p1_q  <= rx.rx_data;
        S_P2:    p2_q  <= rx.rx_data;
        default: ;
      endcase
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      chk_q <= '0;
    else if (byte_in && state_q == S_CHK)
      chk_q <= rx.rx_data;
  end

  assign chk_bad = chk_q != (cmd_q + p0_q + p1_q + p2_q);
`else
  assign chk_bad = 1'b0;
`endif

  assign freq_new = {p2_q[3:0], p1_q, p0_q};

  always_comb begin
    ok_d   = 1'b0;
    err_d  = 1'b0;
    code_d = ERR_NONE;
    set_f  = 1'b0;
    set_m  = 1'b0;
    set_s  = 1'b0;
    go     = 1'b0;
    if (state_q == S_EXEC) begin
      if (chk_bad) begin
        err_d  = 1'b1;
        code_d = ERR_BAD_CHK;
      end else begin
        unique case (1'b1)
          cmd_q == CMD_FREQ: begin
            if (bcd_ok(freq_new) && p2_q[7:4] == 4'd0) begin
              ok_d  = 1'b1;
              set_f = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_BAD_CMD;
            end
          end
          cmd_q == CMD_METHOD: begin
            ok_d  = 1'b1;
            set_m = 1'b1;
          end
          cmd_q == CMD_SWITCH: begin
            ok_d  = 1'b1;
            set_s = 1'b1;
          end
          cmd_q == CMD_START: begin
            ok_d = 1'b1;
            go   = 1'b1;
          end
          default: begin
            err_d  = 1'b1;
            code_d = ERR_BAD_CMD;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      method     <= METHOD_RST;
      freq       <= FREQ_RST;
      switch     <= 1'b0;
      start_send <= 1'b0;
      cmd_ok     <= 1'b0;
      cmd_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      cmd_ok     <= ok_d;
      cmd_err    <= err_d | tmo;
      start_send <= go;
      if (set_f) freq   <= freq_new;
      if (set_m) method <= p0_q;
      if (set_s) switch <= p0_q[0];
      if (tmo)        err_code <= ERR_TIMEOUT;
      else if (err_d) err_code <= code_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: vector table plus timeout/back-to-back/reset sequences.
// Adapts frame length and checksum cases to UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;

  localparam int TMO = 40;

  logic        clk;
  logic        rstn;
  logic [7:0]  method;
  logic [19:0] freq;
  logic        switch;
  logic        start_send;
  logic        cmd_ok;
  logic        cmd_err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  uart_cmd_parser_if rx_if ();

  uart_cmd_parser #(
    .TIMEOUT_CYC (TMO),
    .FREQ_RST    (20'h00010),
    .METHOD_RST  (8'h40)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx_if),
    .method     (method),
    .freq       (freq),
    .switch     (switch),
    .start_send (start_send),
    .cmd_ok     (cmd_ok),
    .cmd_err    (cmd_err),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        bad;
    logic        ok;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  m;
    logic [19:0] f;
    logic        sw;
    logic        st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] d,
                           input logic bad);
    logic [7:0] sum;
    sum = c + a + b + d;
    if (bad) sum = sum ^ 8'hFF;
    send_byte(c);
    send_byte(a);
    send_byte(b);
    send_byte(d);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(sum);
`endif
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] d,
                            input logic bad);
    send_byte(8'hAA);
    send_body(c, a, b, d, bad);
  endtask

  // called at the negedge right after the last byte was sampled
  task automatic expect_exec(input string tag, input logic ok,
                             input logic err, input logic [1:0] code,
                             input logic [7:0] m, input logic [19:0] f,
                             input logic sw, input logic st);
    check({tag, "_early"}, {29'd0, cmd_ok, cmd_err, start_send}, 32'd0);
    @(negedge clk);
    check({tag, "_ok"}, cmd_ok, ok);
    check({tag, "_err"}, cmd_err, err);
    check({tag, "_start"}, start_send, st);
    check({tag, "_code"}, err_code, code);
    check({tag, "_method"}, method, m);
    check({tag, "_freq"}, freq, f);
    check({tag, "_switch"}, switch, sw);
    @(negedge clk);
    check({tag, "_late"}, {29'd0, cmd_ok, cmd_err, start_send}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    add('{8'h01, 8'h45, 8'h23, 8'h01, 0, 1, 0, 2'd0, 8'h40, 20'h12345, 0, 0});
    add('{8'h01, 8'h4A, 8'h00, 8'h00, 0, 0, 1, 2'd1, 8'h40, 20'h12345, 0, 0});
    add('{8'h07, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'd1, 8'h40, 20'h12345, 0, 0});
    add('{8'h02, 8'hAA, 8'h00, 8'h00, 0, 1, 0, 2'd1, 8'hAA, 20'h12345, 0, 0});
    add('{8'h02, 8'h55, 8'h00, 8'h00, 0, 1, 0, 2'd1, 8'h55, 20'h12345, 0, 0});
    add('{8'h03, 8'h01, 8'h00, 8'h00, 0, 1, 0, 2'd1, 8'h55, 20'h12345, 1, 0});
    add('{8'h03, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd1, 8'h55, 20'h12345, 0, 0});
    add('{8'h04, 8'h12, 8'h34, 8'h56, 0, 1, 0, 2'd1, 8'h55, 20'h12345, 0, 1});
    add('{8'h01, 8'h99, 8'h99, 8'h09, 0, 1, 0, 2'd1, 8'h55, 20'h99999, 0, 0});
    add('{8'h01, 8'h00, 8'h00, 8'h10, 0, 0, 1, 2'd1, 8'h55, 20'h99999, 0, 0});
    add('{8'h01, 8'h00, 8'h00, 8'h0A, 0, 0, 1, 2'd1, 8'h55, 20'h99999, 0, 0});
    add('{8'h01, 8'hA0, 8'h00, 8'h00, 0, 0, 1, 2'd1, 8'h55, 20'h99999, 0, 0});
    add('{8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd1, 8'h55, 20'h00000, 0, 0});
    add('{8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'd1, 8'h55, 20'h00000, 0, 0});
    add('{8'h05, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2'd1, 8'h55, 20'h00000, 0, 0});
`ifdef UART_CMD_CHECKSUM_EN
    add('{8'h03, 8'h01, 8'h00, 8'h00, 1, 0, 1, 2'd2, 8'h55, 20'h00000, 0, 0});
    add('{8'h03, 8'h01, 8'h00, 8'h00, 0, 1, 0, 2'd2, 8'h55, 20'h00000, 1, 0});
    add('{8'h03, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd2, 8'h55, 20'h00000, 0, 0});
`endif

    rstn           = 1'b0;
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_method", method, 8'h40);
    check("rst_freq", freq, 20'h00010);
    check("rst_switch", switch, 1'b0);
    check("rst_code", err_code, 2'd0);
    check("rst_pulses", {29'd0, cmd_ok, cmd_err, start_send}, 32'd0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].cmd, vecs[i].p0, vecs[i].p1, vecs[i].p2,
                 vecs[i].bad);
      expect_exec($sformatf("v%0d", i), vecs[i].ok, vecs[i].err,
                  vecs[i].code, vecs[i].m, vecs[i].f, vecs[i].sw,
                  vecs[i].st);
    end

    // inter-byte timeout: error exactly TMO edges after the last byte
    send_byte(8'hAA);
    send_byte(8'h02);
    seen = 0;
    repeat (TMO - 1) begin
      @(negedge clk);
      if (cmd_err) seen++;
    end
    check("tmo_early", seen, 0);
    @(negedge clk);
    check("tmo_err", cmd_err, 1'b1);
    check("tmo_code", err_code, 2'd3);
    check("tmo_method", method, 8'h55);
    @(negedge clk);
    check("tmo_late", cmd_err, 1'b0);
    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 0);
    expect_exec("tmo_start", 1, 0, 2'd3, 8'h55, 20'h00000, 0, 1);

    // garbage, then back-to-back frames with the header in the EXEC cycle
    send_byte(8'h12);
    send_byte(8'h34);
    send_frame(8'h02, 8'h80, 8'h00, 8'h00, 0);
    check("b2b_early", cmd_ok, 1'b0);
    send_byte(8'hAA);
    check("b2b_ok1", cmd_ok, 1'b1);
    check("b2b_method", method, 8'h80);
    send_body(8'h03, 8'h01, 8'h00, 8'h00, 0);
    expect_exec("b2b_f2", 1, 0, 2'd3, 8'h80, 20'h00000, 1, 0);

    // reset in the middle of a frame
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h77);
    rstn = 1'b0;
    #1;
    check("mid_rst_method", method, 8'h40);
    check("mid_rst_freq", freq, 20'h00010);
    check("mid_rst_switch", switch, 1'b0);
    check("mid_rst_code", err_code, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h00);
      if (cmd_ok || cmd_err) seen++;
    end
    repeat (3) begin
      @(negedge clk);
      if (cmd_ok || cmd_err) seen++;
    end
    check("post_rst_quiet", seen, 0);
    check("post_rst_method", method, 8'h40);
    send_frame(8'h02, 8'h33, 8'h00, 8'h00, 0);
    expect_exec("post_rst", 1, 0, 2'd0, 8'h33, 20'h00010, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
